// File: rtl/ifu_fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ifu_fetch_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;
   localparam int IFU_DEPTH = 2;
   localparam logic [XLEN-1:0] IFU_RESET_PC = 32'h0000_0000;

   // One entry of the instruction queue: the returned word and the PC it was fetched from.
   typedef struct packed {
      logic [ILEN-1:0] data;
      logic [XLEN-1:0] pc;
   } inst_ent_t;

   // Instructions are word aligned; the two low address bits carry no information.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifu_fetch_sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; head is read straight from the storage flops.
// Latency: a push is visible at the head the cycle after the push edge.
// Backpressure: pushes when full and pops when empty are ignored; flush wins over push/pop.
// Ports: clk/rst_n, flush, push/push_dat, pop, head_dat (current head), count (occupancy).
module ifu_fetch_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_dat,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_dat,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      do_push  = push && (cnt_q != FULL_CNT);
      do_pop   = pop && (cnt_q != '0);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign head_dat = mem_q[rd_ptr_q];
   assign count    = cnt_q;

endmodule

// File: rtl/ifu_fetch.sv
// Fetch front end: owns the PC, issues word fetches, pairs responses with their PC for decode.
// Latency: request at cycle N, 1-cycle memory response at N+1, inst_valid at N+2.
// Backpressure: requests issue only while in-flight + buffered < DEPTH; inst_ready stalls refill.
// Ports: redirect_* from execute, imem_req_*/imem_rsp_* to instruction memory, inst_* to decode.
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = IFU_RESET_PC,
   parameter int          DEPTH    = IFU_DEPTH
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   output logic [31:0] inst_pc4
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);

   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;
   logic          run_q, run_d;

   logic [CW-1:0] infl_cnt, inst_cnt;
   logic [31:0]   infl_head_pc;
   inst_ent_t     inst_head;
   inst_ent_t     inst_push_ent;
   logic          req_hs, rsp_take, inst_push, inst_pop;

   // run_q holds issue off for the cycle in which reset is still being applied.
   assign imem_req_valid = run_q && (({1'b0, infl_cnt} + {1'b0, inst_cnt}) < CREDIT_MAX);
   assign imem_req_addr  = pc_q;
   assign req_hs         = imem_req_valid && imem_req_ready;

   // A response with nothing outstanding is a protocol error and is ignored here.
   assign rsp_take      = imem_rsp_valid && (infl_cnt != '0);
   assign inst_push     = rsp_take && (drop_cnt_q == '0);
   assign inst_push_ent = '{data: imem_rsp_data, pc: infl_head_pc};
   assign inst_pop      = inst_valid && inst_ready;

   always_comb begin
      pc_d       = pc_q;
      drop_cnt_d = drop_cnt_q;
      run_d      = 1'b1;
      if (redirect_valid) begin
         pc_d = word_align(redirect_pc);
         // Everything still outstanding after this edge belongs to the old path;
         // a same-cycle response is already gone, a same-cycle request is still out.
         drop_cnt_d = infl_cnt + CW'(req_hs) - CW'(rsp_take);
      end else begin
         if (req_hs) begin
            pc_d = pc_q + 32'd4;
         end
         if (rsp_take && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         drop_cnt_q <= '0;
         run_q      <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         drop_cnt_q <= drop_cnt_d;
         run_q      <= run_d;
      end
   end

   // In-flight PC queue: never flushed, stale entries drain through drop_cnt.
   ifu_fetch_sync_fifo #(
      .WIDTH (XLEN),
      .DEPTH (DEPTH)
   ) u_infl_q (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (1'b0),
      .push     (req_hs),
      .push_dat (pc_q),
      .pop      (rsp_take),
      .head_dat (infl_head_pc),
      .count    (infl_cnt)
   );

   ifu_fetch_sync_fifo #(
      .WIDTH ($bits(inst_ent_t)),
      .DEPTH (DEPTH)
   ) u_inst_q (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (redirect_valid),
      .push     (inst_push),
      .push_dat (inst_push_ent),
      .pop      (inst_pop),
      .head_dat (inst_head),
      .count    (inst_cnt)
   );

   // Outputs come from the queue storage flops; forced to zero while empty.
   assign inst_valid = (inst_cnt != '0);
   assign inst_data  = inst_valid ? inst_head.data : 32'd0;
   assign inst_pc    = inst_valid ? inst_head.pc : 32'd0;
   assign inst_pc4   = inst_valid ? (inst_head.pc + 32'd4) : 32'd0;

   a_rsp_has_req: assert property (@(posedge clk) disable iff (!rst_n)
      imem_rsp_valid |-> (infl_cnt != '0));

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

   localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFF8;
   localparam int          TB_DEPTH    = 2;
   localparam logic [31:0] MEM_XOR     = 32'hA5A5_A5A5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic [31:0] inst_pc4;

   always #5 clk = ~clk;

   ifu_fetch #(
      .RESET_PC (TB_RESET_PC),
      .DEPTH    (TB_DEPTH)
   ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_pc4       (inst_pc4)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
   endtask

   // Reference model: program-order view of fetch. Each outstanding fetch carries a
   // "stale" mark set by any later redirect; only unmarked ones reach decode.
   typedef struct {
      logic [31:0] pc;
      bit          stale;
   } ent_t;

   ent_t        m_out[$];
   logic [31:0] m_del[$];
   logic [31:0] m_pc  = TB_RESET_PC;
   bit          m_run = 1'b0;

   // Memory: returns addr ^ MEM_XOR in order, at least one cycle after acceptance.
   logic [31:0] mem_q[$];
   int          mem_mode   = 0;   // 0: next cycle, 1: random delay, 2: hold
   int          p_req_rdy  = 100;
   int          p_inst_rdy = 100;

   task automatic cycle(input bit do_rst, input bit do_redir, input logic [31:0] rpc);
      bit   exp_rv, exp_iv, rv;
      ent_t e;
      @(negedge clk);
      exp_rv = m_run && ((m_out.size() + m_del.size()) < TB_DEPTH);
      exp_iv = (m_del.size() != 0);
      chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
      chk("inst_valid", 32'(inst_valid), 32'(exp_iv));
      if (exp_iv) begin
         chk("inst_pc",   inst_pc,   m_del[0]);
         chk("inst_pc4",  inst_pc4,  m_del[0] + 32'd4);
         chk("inst_data", inst_data, m_del[0] ^ MEM_XOR);
      end else if (!m_run) begin
         chk("rst_inst_data", inst_data, 32'd0);
         chk("rst_inst_pc",   inst_pc,   32'd0);
         chk("rst_inst_pc4",  inst_pc4,  32'd0);
      end

      rst_n          = !do_rst;
      redirect_valid = do_redir;
      redirect_pc    = rpc;
      imem_req_ready = ($urandom_range(99) < p_req_rdy);
      inst_ready     = ($urandom_range(99) < p_inst_rdy);
      case (mem_mode)
         0:       rv = (mem_q.size() != 0);
         1:       rv = (mem_q.size() != 0) && ($urandom_range(1) == 1);
         default: rv = 1'b0;
      endcase
      if (do_rst) rv = 1'b0;
      imem_rsp_valid = rv;
      imem_rsp_data  = rv ? (mem_q[0] ^ MEM_XOR) : $urandom;

      // Effect of the coming edge.
      if (do_rst) begin
         m_out.delete();
         m_del.delete();
         mem_q.delete();
         m_pc  = TB_RESET_PC;
         m_run = 1'b0;
      end else begin
         if (exp_iv && inst_ready) void'(m_del.pop_front());
         if (rv) begin
            if (m_out.size() != 0) begin
               e = m_out.pop_front();
               if (!e.stale) m_del.push_back(e.pc);
            end
            void'(mem_q.pop_front());
         end
         if (imem_req_valid && imem_req_ready) mem_q.push_back(imem_req_addr);
         if (exp_rv && imem_req_ready) begin
            m_out.push_back('{pc: m_pc, stale: 1'b0});
            m_pc = m_pc + 32'd4;
         end
         if (do_redir) begin
            foreach (m_out[i]) m_out[i].stale = 1'b1;
            m_del.delete();
            m_pc = {rpc[31:2], 2'b00};
         end
         m_run = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0);
   endtask

   initial begin
      logic [31:0] rpc;
      // Reset, then streaming across the address wrap with a 1-cycle memory.
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'd0);
      mem_mode = 0; p_req_rdy = 100; p_inst_rdy = 100;
      idle(10);

      // Decode stalls: fetch fills DEPTH slots and stops, then resumes in order.
      p_inst_rdy = 0;
      idle(10);
      p_inst_rdy = 100;
      idle(6);

      // Hold memory so two requests are outstanding, then redirect to a misaligned target.
      mem_mode = 2;
      idle(3);
      mem_mode = 0;
      cycle(1'b0, 1'b1, 32'h0000_0103);
      idle(8);

      // Redirect in steady state: request and response handshakes in the same cycle.
      cycle(1'b0, 1'b1, 32'h0000_2000);
      cycle(1'b0, 1'b1, 32'h0000_3008);
      idle(8);

      // Randomised traffic: stalls on both channels, variable memory delay, redirects.
      mem_mode = 1; p_req_rdy = 60; p_inst_rdy = 70;
      for (int i = 0; i < 2000; i++) begin
         rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                       : $urandom;
         cycle(($urandom_range(299) == 0), ($urandom_range(15) == 0), rpc);
      end

      // Mid-stream reset: outputs clear, fetch restarts at the reset PC.
      mem_mode = 0; p_req_rdy = 100; p_inst_rdy = 100;
      idle(5);
      cycle(1'b1, 1'b0, 32'd0);
      idle(8);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch front end. It owns the architectural PC register and consumes the next-PC redirect produced by the NPC logic in execute.
- Issues word fetches to instruction memory over a valid/ready request channel and accepts in-order responses.
- Pairs each returned instruction with its PC and pc+4, and delivers them to decode through a valid/ready queue.
- On redirect, stale in-flight responses are discarded.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- DEPTH, 2, maximum of (in-flight requests + buffered instructions); power of two, ≥2.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on clk rising edge.
- redirect_valid  in  1  execute requests PC change (taken branch/jump).
- redirect_pc  in  32  new PC (the npc value); bits[1:0] ignored, forced to 0.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  fetch address = current PC.
- imem_rsp_valid  in  1  response valid; in order, ≥1 cycle after acceptance, no backpressure.
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts.
- inst_data  out  32  instruction.
- inst_pc  out  32  its PC.
- inst_pc4  out  32  inst_pc + 4.

Behaviour:
- Reset (rst_n=0 at edge):
  - pc=RESET_PC; both queues emptied; drop_cnt=0.
  - imem_req_valid=0, inst_valid=0, inst_data/inst_pc/inst_pc4=0.
  - Reset mid-operation abandons everything. Memory is reset with the block, so no responses return for pre-reset requests.
- Issue:
  - imem_req_valid = (inflight_cnt + inst_cnt < DEPTH); imem_req_addr = pc. Asserted the first cycle after reset release.
  - On request handshake: push pc into the in-flight PC queue; pc <= pc+4 (32-bit wrap, 0xFFFF_FFFC+4 -> 0).
- Response:
  - On imem_rsp_valid, pop the in-flight PC queue.
  - If drop_cnt>0: discard and decrement drop_cnt.
  - Else push {data, pc} into the instruction queue.
  - A response with an empty in-flight queue is a protocol error: simulation assertion, ignored in RTL.
- Delivery:
  - inst_valid = instruction queue non-empty; outputs are registered queue head. No combinational path from imem_rsp to inst_*.
  - Latency with a 1-cycle memory: request at cycle N, response at N+1, inst_valid at N+2.
  - inst_pc4 computed from the head entry, 32-bit wrap.
- Redirect (redirect_valid=1 at an edge), taking priority over all same-cycle updates:
  - pc <= {redirect_pc[31:2],2'b00}.
  - Instruction queue flushed. A same-cycle inst handshake still counts as consumed.
  - drop_cnt <= number of requests in flight after this edge. This includes a request handshaked in the same cycle (its address is the old pc) and excludes a response arriving in the same cycle (that response is discarded).
  - The in-flight PC queue is not flushed. Its entries drain via drop_cnt.
  - Issue resumes next cycle at the new pc once credit allows.
- Back-to-back redirects: drop_cnt recomputed each time per the rule above; never underflows.
- Full: when inflight_cnt+inst_cnt == DEPTH, imem_req_valid=0 until decode pops or a drop frees an in-flight slot.
- Stable-request rule: while imem_req_valid=1 and imem_req_ready=0, addr is held, unless a redirect occurs (address change permitted; the un-accepted request is not counted).
- Invariant: inflight_cnt + inst_cnt ≤ DEPTH; drop_cnt ≤ inflight_cnt.

Decomposition:
- defines.vh (shared, alongside the NPC opcode macros): XLEN=32, ILEN=32, IFU_DEPTH default, RESET_PC default.
- One natural sub-module: sync_fifo (parameterised WIDTH, DEPTH, synchronous active-low reset, flush input, count output). Instantiated twice:
  - in-flight PC queue (WIDTH 32);
  - instruction queue (WIDTH 64).
- Counters, credit, drop logic and PC register live in ifu_fetch.

Test Plan:
- Reset then ready=1, 1-cycle memory returning addr^0xA5A5_A5A5, inst_ready=1:
  - req addrs 0x0,0x4,0x8 on consecutive cycles;
  - first inst_valid 2 cycles after first request with inst_pc=0x0, inst_pc4=0x4;
  - steady one instruction per cycle.
- inst_ready=0 for 10 cycles: exactly DEPTH=2 requests issued (0x0,0x4), then imem_req_valid=0. Release ready -> instructions 0x0,0x4 delivered in order, fetch resumes at 0x8.
- Redirect to 0x0000_0103 while 2 requests are in flight:
  - next request addr 0x0000_0100;
  - both stale responses dropped;
  - first delivered inst_pc=0x100; no inst_valid with stale PCs.
- Redirect in the same cycle as a request handshake and a response: drop_cnt ends correct; only the post-redirect PC sequence is ever delivered.
- imem_req_ready toggled 0/1 randomly: addr stable while stalled; every pc delivered exactly once in order.
- RESET_PC=32'hFFFF_FFF8: fetch 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0; inst_pc4 of 0xFFFF_FFFC is 0x0. Assert rst_n mid-stream -> all outputs 0 next cycle, restart at RESET_PC.
